// File: rtl/mod_port_pkg.sv
// Shared constants and types for the modulo counter slice.
package mod_port_pkg;

  localparam int COUNT_W   = 4;
  localparam int COUNT_MOD = 12;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  typedef logic [COUNT_W-1:0] count_t;

endpackage : mod_port_pkg

// File: rtl/mod_port_next.sv
// Combinational next-count logic: load with range check, up wrap, down wrap.
module mod_port_next
  import mod_port_pkg::*;
#(
  parameter int WIDTH   = COUNT_W,
  parameter int MODULUS = COUNT_MOD
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] datain,
  input  logic             load,
  input  logic             mode,
  output logic [WIDTH-1:0] next_count
);

  // Highest legal count, at both the extended and the native width.
  localparam logic [WIDTH:0]   LAST_X = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LAST_W = WIDTH'(MODULUS - 1);

  // Load value; anything beyond the last legal count collapses to zero.
  function automatic logic [WIDTH-1:0] load_sat(input logic [WIDTH-1:0] d);
    logic [WIDTH:0] d_x;
    d_x = {1'b0, d};
    return (d_x > LAST_X) ? '0 : d;
  endfunction

  // Up step computed one bit wider so the carry out of WIDTH bits is visible.
  function automatic logic [WIDTH-1:0] wrap_up(input logic [WIDTH-1:0] c);
    logic [WIDTH:0] inc_x;
    inc_x = {1'b0, c} + 1'b1;
    return (inc_x > LAST_X) ? '0 : inc_x[WIDTH-1:0];
  endfunction

  // Down step; a borrow into the extra bit means we stepped below zero.
  function automatic logic [WIDTH-1:0] wrap_down(input logic [WIDTH-1:0] c);
    logic [WIDTH:0] dec_x;
    dec_x = {1'b0, c} - 1'b1;
    return dec_x[WIDTH] ? LAST_W : dec_x[WIDTH-1:0];
  endfunction

  // Select between load, up and down; load overrides direction.
  always_comb begin
    next_count = count;
    if (load) begin
      next_count = load_sat(datain);
    end else if (mode == MODE_UP) begin
      next_count = wrap_up(count);
    end else begin
      next_count = wrap_down(count);
    end
  end

endmodule : mod_port_next

// File: rtl/mod_port.sv
// Loadable modulo up/down counter: state register plus synchronous reset.
module mod_port
  import mod_port_pkg::*;
#(
  parameter int WIDTH   = COUNT_W,
  parameter int MODULUS = COUNT_MOD
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] datain,
  input  logic             load,
  input  logic             mode,
  output logic [WIDTH-1:0] dataout
);

  logic [WIDTH-1:0] count_p0;
  logic [WIDTH-1:0] next_p0;

  mod_port_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count      (count_p0),
    .datain     (datain),
    .load       (load),
    .mode       (mode),
    .next_count (next_p0)
  );

  // Count register; reset wins over load and count.
  always_ff @(posedge clock) begin
    if (rst) begin
      count_p0 <= '0;
    end else begin
      count_p0 <= next_p0;
    end
  end

  assign dataout = count_p0;

endmodule : mod_port

// File: tb/tb_mod_port.sv
// Directed and random checks of the modulo-12 loadable up/down counter.
module tb_mod_port;

  logic       clock;
  logic       rst;
  logic [3:0] datain;
  logic       load;
  logic       mode;
  logic [3:0] dataout;

  int total;
  int passed;

  mod_port dut (
    .clock   (clock),
    .rst     (rst),
    .datain  (datain),
    .load    (load),
    .mode    (mode),
    .dataout (dataout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply inputs 1 unit after an edge, then land 1 unit after the next edge.
  task automatic cycle(input logic r, input logic l, input int d, input logic m);
    rst    = r;
    load   = l;
    datain = 4'(d);
    mode   = m;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input int exp);
    logic [3:0] e;
    e = 4'(exp);
    total++;
    assert (dataout === e) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, dataout, e);
  endtask

  initial begin
    int model;
    logic r, l, m;
    int d;

    total  = 0;
    passed = 0;
    rst    = 1'b1;
    load   = 1'b1;
    datain = 4'd7;
    mode   = 1'b1;
    @(posedge clock);
    #1;

    // Reset with load asserted, held two cycles
    cycle(1, 1, 7, 1); check("reset_a", 0);
    cycle(1, 1, 7, 1); check("reset_b", 0);
    cycle(0, 0, 0, 1); check("post_reset_1", 1);
    cycle(0, 0, 0, 1); check("post_reset_2", 2);
    cycle(0, 0, 0, 1); check("post_reset_3", 3);

    // Up wrap
    cycle(0, 1, 10, 1); check("upwrap_load", 10);
    cycle(0, 0, 0, 1);  check("upwrap_11", 11);
    cycle(0, 0, 0, 1);  check("upwrap_0", 0);
    cycle(0, 0, 0, 1);  check("upwrap_1", 1);

    // Down wrap
    cycle(0, 1, 1, 0); check("dnwrap_load", 1);
    cycle(0, 0, 0, 0); check("dnwrap_0", 0);
    cycle(0, 0, 0, 0); check("dnwrap_11", 11);
    cycle(0, 0, 0, 0); check("dnwrap_10", 10);

    // Load beats counting, mode ignored during load
    cycle(0, 1, 4, 1); check("prio_load4", 4);
    cycle(0, 0, 0, 1); check("prio_count5", 5);
    cycle(0, 1, 9, 0); check("prio_load9", 9);

    // Reset beats load
    cycle(1, 1, 5, 1); check("rst_over_load", 0);

    // Out-of-range loads
    cycle(0, 1, 13, 1); check("load13", 0);
    cycle(0, 1, 15, 0); check("load15", 0);
    cycle(0, 1, 11, 1); check("load11", 11);
    cycle(0, 1, 12, 1); check("load12", 0);
    cycle(0, 1, 0, 0);  check("load0", 0);

    // Held load follows datain
    cycle(0, 1, 3, 1); check("held_3", 3);
    cycle(0, 1, 8, 0); check("held_8", 8);

    // Direction switch, then mid-run reset
    cycle(0, 1, 2, 1); check("dir_load2", 2);
    cycle(0, 0, 0, 1); check("dir_up3", 3);
    cycle(0, 0, 0, 1); check("dir_up4", 4);
    cycle(0, 0, 0, 1); check("dir_up5", 5);
    cycle(0, 0, 0, 0); check("dir_dn4", 4);
    cycle(0, 0, 0, 0); check("dir_dn3", 3);
    cycle(1, 0, 0, 0); check("mid_reset", 0);
    cycle(0, 0, 0, 0); check("resume_dn11", 11);

    // Random run against a modulo-arithmetic reference model
    model = 11;
    for (int i = 0; i < 1000; i++) begin
      r = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 3) == 0);
      d = int'($urandom_range(0, 15));
      m = 1'($urandom_range(0, 1));
      cycle(r, l, d, m);
      if (r)      model = 0;
      else if (l) model = (d < 12) ? d : 0;
      else if (m) model = (model + 1) % 12;
      else        model = (model + 11) % 12;
      total++;
      assert (dataout <= 4'd11) passed++;
      else $error("FAIL range cycle %0d: observed %0d required <= 11", i, dataout);
      check("random_model", model);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mod_port
